// File: rtl/ixc_assign_arb_pkg.sv
// Shared definitions for the ixc_assign channel arbiter.
//   - arbiter state encoding
//   - clog2 helper that sizes requester index fields
//   - default channel geometry (19-bit assign slice, 4 requesters)
package ixc_assign_arb_pkg;

  localparam int unsigned DefaultW    = 19;
  localparam int unsigned DefaultNreq = 4;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

  // Ceiling log2, never less than 1 so an index field always has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ixc_rr_pick.sv
// Round-robin candidate search: first set bit of req starting at ptr, wrapping
// modulo NREQ.
//   req   - candidate request vector
//   ptr   - index the search starts from (0..NREQ-1)
//   idx   - index of the first set bit found
//   found - at least one bit of req is set
module ixc_rr_pick
  import ixc_assign_arb_pkg::*;
#(
  parameter int unsigned NREQ = DefaultNreq
) (
  input  logic [NREQ-1:0]         req,
  input  logic [clog2(NREQ)-1:0]  ptr,
  output logic [clog2(NREQ)-1:0]  idx,
  output logic                    found
);

  localparam int unsigned SW = clog2(NREQ);
  localparam logic [SW-1:0] LastIdx = SW'(NREQ - 1);

  logic [SW-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = ptr;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = (cand == LastIdx) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/ixc_assign_arb.sv
// Round-robin, burst-locking arbiter sharing one W-bit ixc_assign channel among
// NREQ requesters. A grant is held until the owner's last beat is accepted, or
// until the owner has shown no valid beat for IDLE_TO granted cycles.
//   clk, rst_n   - clock, asynchronous active-low reset
//   req_valid    - per-requester beat valid
//   req_data     - requester i data at [i*W +: W]
//   req_last     - per-requester last-beat flag
//   req_ready    - beat from requester i accepted this cycle
//   out_valid    - registered channel beat valid
//   out_data     - registered channel data (assign slice R input)
//   out_src      - requester that produced out_data
//   out_last     - registered last flag
//   out_ready    - downstream accepts the beat
//   busy         - a grant is currently held
//   err_timeout  - one-cycle pulse when the idle watchdog releases a grant
module ixc_assign_arb
  import ixc_assign_arb_pkg::*;
#(
  parameter int unsigned NREQ    = DefaultNreq,
  parameter int unsigned W       = DefaultW,
  parameter int unsigned IDLE_TO = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*W-1:0]      req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  output logic [clog2(NREQ)-1:0] out_src,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int unsigned SW = clog2(NREQ);
  localparam int unsigned CW = 8;
  localparam logic [SW-1:0] LastIdx   = SW'(NREQ - 1);
  localparam logic [CW-1:0] IdleLimit = CW'(IDLE_TO);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic          timeout_d;

  logic [SW-1:0] pick_idx;
  logic          pick_found;
  logic [SW-1:0] owner_next;
  logic          owner_valid;
  logic          owner_last;
  logic [W-1:0]  owner_data;
  logic          load;

  ixc_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];
  assign owner_data  = req_data[owner_q*W +: W];
  assign owner_next  = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;

  // Accept a beat only while granted and the output register is free or draining.
  assign load = (state_q == StGrant) && owner_valid && (!out_valid || out_ready);
  assign busy = (state_q == StGrant);

  always_comb begin
    req_ready = '0;
    if (load) begin
      req_ready[owner_q] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    idle_cnt_d = idle_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      StIdle: begin
        idle_cnt_d = '0;
        if (pick_found) begin
          owner_d = pick_idx;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (owner_valid) begin
          // A valid owner beat, accepted or backpressured, is not idleness.
          idle_cnt_d = '0;
          if (load && owner_last) begin
            rr_ptr_d = owner_next;
            state_d  = StIdle;
          end
        end else if (idle_cnt_q + 1'b1 == IdleLimit) begin
          idle_cnt_d = '0;
          rr_ptr_d   = owner_next;
          state_d    = StIdle;
          timeout_d  = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      idle_cnt_q  <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      idle_cnt_q  <= idle_cnt_d;
      err_timeout <= timeout_d;
    end
  end

  // Output stage: data/src/last only change on a load, so a stalled beat stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= owner_data;
      out_src   <= owner_q;
      out_last  <= owner_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/ixc_assign_arb.md
Name: ixc_assign_arb

Overview:
- Round-robin, burst-locking arbiter that shares one W-bit assign channel among NREQ requesters.
- The channel is a 19-bit ixc_assign bit-slice instance downstream in the IXCOM template library.
- A grant is held for a whole burst, up to and including the beat flagged last. Output is registered with valid/ready flow control.
- An idle-owner watchdog releases a stalled grant and flags an error.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 19, channel data width; matches the downstream assign slice.
- IDLE_TO, 15, cycles a granted owner may present no valid beat before forced release (1..255).

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_data  in  NREQ*W  requester i data at [i*W +: W].
- req_last  in  NREQ  beat is the last of its burst.
- req_ready  out  NREQ  beat accepted from requester i this cycle.
- out_valid  out  1  registered channel beat valid.
- out_data  out  W  registered channel data, driven onto the assign slice R input.
- out_src  out  clog2(NREQ)  index of the requester that produced out_data.
- out_last  out  1  registered last flag.
- out_ready  in  1  downstream accepts the beat.
- busy  out  1  a grant is currently held.
- err_timeout  out  1  one-cycle pulse when the watchdog releases a grant.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - On rst_n=0 (async) the state goes to IDLE and every output and register clears: rr_ptr=0, owner=0, out_valid=0, out_data=0, out_src=0, out_last=0, busy=0, err_timeout=0, idle counter=0.
  - Outputs are driven low until the first clk edge after deassertion.
- Output register:
  - load = req_valid[owner] & state==GRANT & (~out_valid | out_ready).
  - req_ready[owner] = load. All other req_ready bits are 0.
  - Data, src and last appear one cycle after acceptance (latency 1).
  - Full throughput: one beat per cycle when out_ready is held high.
- out_valid:
  - Cleared on out_ready when no load occurs that cycle.
  - Holds, with stable data, while out_valid=1 and out_ready=0.
- IDLE state:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward, with modulo-NREQ wrap.
  - Set owner to that index and move to GRANT next cycle. Arbitration costs one cycle and no beat is accepted in IDLE.
- GRANT state:
  - busy=1.
  - On a load with req_last[owner]=1: rr_ptr = (owner+1) mod NREQ, then go to IDLE.
  - The winning beat is still loaded that cycle.
- Watchdog:
  - The idle counter increments each GRANT cycle with req_valid[owner]=0 and resets on any owner valid.
  - When the counter reaches IDLE_TO: go to IDLE, rr_ptr=(owner+1) mod NREQ, err_timeout=1 for one cycle, counter=0.
  - Cycles with owner valid but backpressured (out_ready=0) do not count.
- Request visibility:
  - Non-owner requests are ignored during a burst.
  - A requester dropping valid mid-burst keeps the grant until last or timeout.
- Simultaneous events:
  - last acceptance and watchdog expiry cannot coincide, because a load implies valid.
  - New requests arriving in the same cycle the owner finishes are seen in the next IDLE evaluation.
- Other boundaries:
  - A single-beat burst (last on the first beat) occupies 2 cycles per grant, IDLE plus GRANT.
  - rr_ptr wraps from NREQ-1 to 0.
  - Asserting reset mid-burst drops any in-flight out_valid beat; no partial-burst recovery.

Decomposition:
- Package ixc_assign_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - function clog2 sizing for out_src;
  - constant defaults W=19, NREQ=4.
- Sub-module ixc_rr_pick:
  - combinational first-set-bit search from rr_ptr with wrap;
  - outputs index and found.

Test Plan:
- Reset: assert rst_n=0 mid-burst with out_valid=1 -> all outputs 0 immediately. After release, the first grant goes to req 0 when requesters 0 and 2 are valid.
- Round robin: all 4 requesters issue continuous 1-beat bursts with out_ready=1 -> out_src sequence 0,1,2,3,0. One beat every 2 cycles.
- Burst lock: req1 issues a 5-beat burst (data 0x00001..0x00005, last on beat 5) while req0 and req3 request -> 5 consecutive beats with src=1. Next grant goes to req3, then req0.
- Backpressure: out_ready=0 for 3 cycles mid-burst -> out_data holds 0x7FFFF stable. req_ready=0. No watchdog count; the burst resumes without loss.
- Watchdog (IDLE_TO=15): req2 sends 1 beat without last, then drops valid -> after 15 cycles err_timeout pulses once, busy=0, and the next grant goes to req3.
- Wrap and data width: req3 bursts 0x7FFFF then 0x40001 -> full 19 bits pass intact. rr_ptr wraps to 0.
